// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - registered ALU: single-cycle logic/arith, iterative shifts and shift-add multiply
module iterative_alu #(
    parameter int WIDTH      = 16,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       Op,
    input  logic             Swap,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Q,
    output logic             Carry,
    output logic             Zero,
    output logic             Minus1
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_PASS = 5'b00000;
    localparam logic [4:0] OP_NOT  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_ADD  = 5'b01001;
    localparam logic [4:0] OP_ADC  = 5'b01010;
    localparam logic [4:0] OP_SUB  = 5'b01011;
    localparam logic [4:0] OP_INC  = 5'b01100;
    localparam logic [4:0] OP_DEC  = 5'b01101;
    localparam logic [4:0] OP_SHL  = 5'b10000;
    localparam logic [4:0] OP_SHR  = 5'b10001;
    localparam logic [4:0] OP_ASR  = 5'b10010;
    localparam logic [4:0] OP_MUL  = 5'b10100;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, nextState;
    logic [WIDTH-1:0]   aS, bS;
    logic [SW-1:0]      k;
    logic               isShift, isMul, goRun, capture, lastStep;
    logic [WIDTH-1:0]   aluQ;
    logic               aluC;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     immStep, runStep;
    logic [2*WIDTH-1:0] mulSum;
    logic               wrEn, wrC;
    logic [WIDTH-1:0]   wrQ;

    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, work;
    logic [SW-1:0]      cnt;
    logic               runMul;
    logic [1:0]         runKind;
    logic [WIDTH-1:0]   qReg;
    logic               carryReg, zeroReg, minusReg, doneReg;

    // One shift step: returns {bit shifted out, shifted value}
    function automatic logic [WIDTH:0] shiftStep(input logic [1:0] kind, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        case (kind)
            2'b00:   r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            2'b01:   r = {v[0], 1'b0, v[WIDTH-1:1]};
            default: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign aS      = Swap ? B : A;
    assign bS      = Swap ? A : B;
    assign k       = bS[SW-1:0];
    assign isShift = (Op == OP_SHL) || (Op == OP_SHR) || (Op == OP_ASR);
    assign isMul   = MUL_ENABLE && (Op == OP_MUL);
    assign goRun   = isMul || (isShift && (k > SW'(1)));
    assign capture = (state == IDLE) && Start;
    assign lastStep = (state == RUN) && (cnt == SW'(1));

    assign immStep = shiftStep(Op[1:0], aS);
    assign runStep = shiftStep(runKind, work);
    assign mulSum  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        aluQ = '0;
        aluC = 1'b0;
        sum  = '0;
        case (Op)
            OP_PASS: aluQ = aS;
            OP_NOT:  aluQ = ~aS;
            OP_AND:  aluQ = aS & bS;
            OP_OR:   aluQ = aS | bS;
            OP_XOR:  aluQ = aS ^ bS;
            OP_ADD:  sum = {1'b0, aS} + {1'b0, bS};
            OP_ADC:  sum = {1'b0, aS} + {1'b0, bS} + {{WIDTH{1'b0}}, carryReg};
            OP_SUB:  sum = {1'b0, aS} + {1'b0, ~bS} + (WIDTH+1)'(1);
            OP_INC:  sum = {1'b0, aS} + (WIDTH+1)'(1);
            OP_DEC:  sum = {1'b0, aS} + {1'b0, {WIDTH{1'b1}}};
            default: ;
        endcase
        if (Op == OP_ADD || Op == OP_ADC || Op == OP_SUB || Op == OP_INC || Op == OP_DEC) begin
            aluQ = sum[WIDTH-1:0];
            aluC = sum[WIDTH];
        end
    end

    // Result source: immediate path at capture, or final iteration in RUN
    always_comb begin
        wrEn = 1'b0;
        wrQ  = '0;
        wrC  = 1'b0;
        if (capture && !goRun) begin
            wrEn = 1'b1;
            if (isShift) begin
                if (k == '0) wrQ = aS;
                else {wrC, wrQ} = immStep;
            end else begin
                wrQ = aluQ;
                wrC = aluC;
            end
        end else if (lastStep) begin
            wrEn = 1'b1;
            if (runMul) begin
                wrQ = mulSum[WIDTH-1:0];
                wrC = |mulSum[2*WIDTH-1:WIDTH];
            end else begin
                {wrC, wrQ} = runStep;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (capture && goRun) nextState = RUN;
            RUN:     if (lastStep) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Ready = (state == IDLE);
    end

    // The capture edge already performs the first iteration, so RUN needs one cycle fewer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            work     <= '0;
            cnt      <= '0;
            runMul   <= 1'b0;
            runKind  <= 2'b00;
            qReg     <= '0;
            carryReg <= 1'b0;
            zeroReg  <= 1'b0;
            minusReg <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= wrEn;
            if (wrEn) begin
                qReg     <= wrQ;
                carryReg <= wrC;
                zeroReg  <= (wrQ == '0);
                minusReg <= &wrQ;
            end
            if (capture && goRun) begin
                runMul  <= isMul;
                runKind <= Op[1:0];
                if (isMul) begin
                    acc    <= bS[0] ? {{WIDTH{1'b0}}, aS} : '0;
                    mcand  <= {{(WIDTH-1){1'b0}}, aS, 1'b0};
                    mplier <= bS >> 1;
                    cnt    <= SW'(WIDTH-1);
                end else begin
                    work <= immStep[WIDTH-1:0];
                    cnt  <= k - SW'(1);
                end
            end else if (state == RUN) begin
                acc    <= mulSum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                work   <= runStep[WIDTH-1:0];
                cnt    <= cnt - SW'(1);
            end
        end
    end

    assign Done   = doneReg;
    assign Q      = qReg;
    assign Carry  = carryReg;
    assign Zero   = zeroReg;
    assign Minus1 = minusReg;

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - directed self-checking bench for iterative_alu (WIDTH=16)
module tb_iterative_alu;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [4:0]  Op = 5'b0;
    logic        Swap = 1'b0;
    logic [15:0] A = 16'h0;
    logic [15:0] B = 16'h0;
    logic        Ready, Done, Carry, Zero, Minus1;
    logic [15:0] Q;

    int nVec = 0;
    int nFail = 0;

    iterative_alu #(.WIDTH(16), .MUL_ENABLE(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Swap(Swap),
        .A(A), .B(B), .Ready(Ready), .Done(Done), .Q(Q),
        .Carry(Carry), .Zero(Zero), .Minus1(Minus1)
    );

    always #5 Clk = ~Clk;

    // Issue one request and wait (bounded) for Done; res = {Q, Carry, Zero, Minus1}
    task automatic doOp(input logic [4:0] op, input logic sw, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [18:0] res, output logic rdyAtDone);
        int cycles;
        @(negedge Clk);
        Op = op; Swap = sw; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; A = 16'($urandom); B = 16'($urandom); Swap = ~sw;
        cycles = 1;
        while (!Done && cycles < 200) begin
            @(posedge Clk); #1;
            cycles++;
        end
        lat = Done ? cycles : -1;
        res = {Q, Carry, Zero, Minus1};
        rdyAtDone = Ready;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        nVec++;
        if ({Ready, Done, Q, Carry, Zero, Minus1} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            nFail++;
            $display("FAIL reset_state got %b expected %b", {Ready, Done, Q, Carry, Zero, Minus1}, {1'b1, 1'b0, 16'h0, 3'b000});
        end
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic test_arith;
        logic [4:0]  ops [6] = '{5'b01001, 5'b01001, 5'b01010, 5'b01011, 5'b01001, 5'b01101};
        logic        sws [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] as  [6] = '{16'h4444, 16'hff00, 16'h0001, 16'h7777, 16'h7777, 16'h0000};
        logic [15:0] bs  [6] = '{16'h2345, 16'h0100, 16'h0001, 16'h8888, 16'h8888, 16'h0000};
        logic [18:0] exp [6] = '{{16'h6789, 3'b000}, {16'h0000, 3'b110}, {16'h0003, 3'b000},
                                 {16'heeef, 3'b000}, {16'hffff, 3'b001}, {16'hffff, 3'b001}};
        int lat;
        logic [18:0] res;
        logic rdy;
        for (int i = 0; i < 6; i++) begin
            doOp(ops[i], sws[i], as[i], bs[i], lat, res, rdy);
            nVec++;
            if (res !== exp[i] || lat !== 1 || rdy !== 1'b1) begin
                nFail++;
                $display("FAIL arith[%0d] got res=%h lat=%0d rdy=%b expected res=%h lat=1 rdy=1", i, res, lat, rdy, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  ops [8] = '{5'b01100, 5'b01100, 5'b00100, 5'b00010, 5'b00011, 5'b00001, 5'b00101, 5'b00000};
        logic        sws [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] as  [8] = '{16'h0000, 16'hffff, 16'hff00, 16'hff00, 16'hff00, 16'h0000, 16'h1234, 16'h1111};
        logic [15:0] bs  [8] = '{16'h0000, 16'h0000, 16'h0ff0, 16'h0ff0, 16'h0ff0, 16'h0000, 16'h5678, 16'h2222};
        logic [18:0] exp [8] = '{{16'h0001, 3'b000}, {16'h0000, 3'b110}, {16'hf0f0, 3'b000}, {16'h0f00, 3'b000},
                                 {16'hfff0, 3'b000}, {16'hffff, 3'b001}, {16'h0000, 3'b010}, {16'h2222, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Op = ops[i]; Swap = sws[i]; A = as[i]; B = bs[i]; Start = 1'b1;
            @(posedge Clk); #1;
            nVec++;
            if ({Done, Ready, Q, Carry, Zero, Minus1} !== {2'b11, exp[i]}) begin
                nFail++;
                $display("FAIL b2b[%0d] got done/rdy/res=%b/%b/%h expected 1/1/%h", i, Done, Ready, {Q, Carry, Zero, Minus1}, exp[i]);
            end
        end
        @(negedge Clk); Start = 1'b0; A = 16'hdead; Op = 5'b00000;
        @(posedge Clk); #1;
        nVec++;
        if ({Done, Q} !== {1'b0, 16'h2222}) begin
            nFail++;
            $display("FAIL b2b_hold got done=%b q=%h expected done=0 q=2222", Done, Q);
        end
    endtask

    task automatic test_shift;
        logic [4:0]  ops [6] = '{5'b10000, 5'b10010, 5'b10001, 5'b10001, 5'b10000, 5'b10000};
        logic        sws [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] as  [6] = '{16'h8001, 16'h8000, 16'h1234, 16'h00f8, 16'h0003, 16'h0001};
        logic [15:0] bs  [6] = '{16'h0001, 16'h000f, 16'h0000, 16'h0004, 16'h00f0, 16'hfff2};
        logic [18:0] exp [6] = '{{16'h0002, 3'b100}, {16'hffff, 3'b001}, {16'h1234, 3'b000},
                                 {16'h000f, 3'b100}, {16'h0780, 3'b000}, {16'h0004, 3'b000}};
        int          lats[6] = '{1, 15, 1, 4, 3, 2};
        int lat;
        logic [18:0] res;
        logic rdy;
        for (int i = 0; i < 6; i++) begin
            doOp(ops[i], sws[i], as[i], bs[i], lat, res, rdy);
            nVec++;
            if (res !== exp[i] || lat !== lats[i]) begin
                nFail++;
                $display("FAIL shift[%0d] got res=%h lat=%0d expected res=%h lat=%0d", i, res, lat, exp[i], lats[i]);
            end
        end
    endtask

    task automatic test_mul;
        int lat;
        logic [18:0] res;
        logic rdy;
        doOp(5'b10100, 1'b0, 16'h0123, 16'h0045, lat, res, rdy);
        nVec++;
        if (res !== {16'h4e6f, 3'b000} || lat !== 16) begin
            nFail++;
            $display("FAIL mul_basic got res=%h lat=%0d expected res=%h lat=16", res, lat, {16'h4e6f, 3'b000});
        end
        doOp(5'b10100, 1'b1, 16'h0010, 16'h1000, lat, res, rdy);
        nVec++;
        if (res !== {16'h0000, 3'b110} || lat !== 16) begin
            nFail++;
            $display("FAIL mul_overflow got res=%h lat=%0d expected res=%h lat=16", res, lat, {16'h0000, 3'b110});
        end
    endtask

    task automatic test_mul_ignore_start;
        int cycles;
        int earlyDone;
        logic rdyMid;
        logic [15:0] qMid;
        @(negedge Clk);
        Op = 5'b10100; Swap = 1'b0; A = 16'h00ff; B = 16'h0101; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        cycles = 1;
        earlyDone = 0;
        rdyMid = 1'b1;
        qMid = 16'hxxxx;
        while (!Done && cycles < 200) begin
            if (cycles == 4) begin
                @(negedge Clk);
                Op = 5'b00000; A = 16'hffff; Start = 1'b1;
                rdyMid = Ready;
            end
            @(posedge Clk); #1;
            Start = 1'b0;
            cycles++;
            if (cycles == 8) qMid = Q;
            if (Done && cycles < 16) earlyDone++;
        end
        nVec++;
        if (rdyMid !== 1'b0 || qMid !== 16'h0000) begin
            nFail++;
            $display("FAIL mul_busy got ready=%b q=%h expected ready=0 q=0000", rdyMid, qMid);
        end
        nVec++;
        if (cycles !== 16 || earlyDone !== 0 || {Q, Carry, Zero, Minus1} !== {16'hffff, 3'b001}) begin
            nFail++;
            $display("FAIL mul_ignore got lat=%0d early=%0d res=%h expected lat=16 early=0 res=%h",
                     cycles, earlyDone, {Q, Carry, Zero, Minus1}, {16'hffff, 3'b001});
        end
        @(posedge Clk); #1;
        nVec++;
        if (Done !== 1'b0) begin
            nFail++;
            $display("FAIL mul_single_done got done=%b expected 0", Done);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat;
        int doneSeen;
        logic [18:0] res;
        logic rdy;
        doOp(5'b10100, 1'b0, 16'h1000, 16'h0010, lat, res, rdy);
        nVec++;
        if (Carry !== 1'b1) begin
            nFail++;
            $display("FAIL rst_pre_carry got %b expected 1", Carry);
        end
        @(negedge Clk);
        Op = 5'b10100; A = 16'h0123; B = 16'h0045; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        nVec++;
        if ({Ready, Done, Q, Carry, Zero, Minus1} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            nFail++;
            $display("FAIL rst_mid got %b expected %b", {Ready, Done, Q, Carry, Zero, Minus1}, {1'b1, 1'b0, 16'h0, 3'b000});
        end
        @(negedge Clk); Reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (Done) doneSeen++;
        end
        nVec++;
        if (doneSeen !== 0 || Q !== 16'h0) begin
            nFail++;
            $display("FAIL rst_no_done got dones=%0d q=%h expected dones=0 q=0000", doneSeen, Q);
        end
        doOp(5'b01010, 1'b0, 16'h0001, 16'h0001, lat, res, rdy);
        nVec++;
        if (res !== {16'h0002, 3'b000} || lat !== 1) begin
            nFail++;
            $display("FAIL rst_adc got res=%h lat=%0d expected res=%h lat=1", res, lat, {16'h0002, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_shift();
        test_mul();
        test_mul_ignore_start();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
